// File: rtl/log_div_pkg.sv
// Shared width helpers, default configuration and flag types for the
// pipelined Mitchell log-domain divider.
package log_div_pkg;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Bits needed to hold a leading-one position 0..w-1.
   function automatic int kw_f(input int w);
      return (w < 2) ? 1 : clog2_f(w);
   endfunction

   // Signed log-difference width: covers +/-(max(dw,yw) * 2^fw) with a sign bit.
   function automatic int lw_f(input int dw, input int yw, input int fw);
      int mx;
      mx = (dw > yw) ? dw : yw;
      return clog2_f(mx + 1) + fw + 1;
   endfunction

   localparam int DW_DEF = 64;
   localparam int YW_DEF = 32;
   localparam int FW_DEF = 8;
   localparam int QW_DEF = 8;
   localparam int QF_DEF = 8;
   localparam int LW_DEF = lw_f(DW_DEF, YW_DEF, FW_DEF);

   typedef struct packed {
      logic zx;
      logic zy;
   } zflags_t;

endpackage

// File: rtl/lod_norm.sv
// Leading-one detector with normalised fraction: reports the top set bit of
// val_i and the FW bits just below it, zero-padded on the right.
module lod_norm
   import log_div_pkg::*;
#(
   parameter int W  = 64,
   parameter int FW = 8,
   localparam int KW = kw_f(W)
) (
   input  logic [W-1:0]  val_i,
   output logic [KW-1:0] k_o,
   output logic [FW-1:0] f_o,
   output logic          zero_o
);

   // cand[p] is the fraction that results if the leading one sits at bit p.
   logic [FW-1:0] cand [W];

   for (genvar gi = 0; gi < W; gi++) begin : g_pos
      logic [FW-1:0] c;
      for (genvar gj = 0; gj < FW; gj++) begin : g_bit
         if (gi - 1 - gj >= 0) begin : g_src
            assign c[FW-1-gj] = val_i[gi-1-gj];
         end else begin : g_pad
            assign c[FW-1-gj] = 1'b0;
         end
      end
      assign cand[gi] = c;
   end

   always_comb begin
      k_o = '0;
      f_o = '0;
      for (int i = 0; i < W; i++) begin
         if (val_i[i]) begin
            k_o = KW'(i);
            f_o = cand[i];
         end
      end
   end

   assign zero_o = ~|val_i;

endmodule

// File: rtl/log_divider_pipe.sv
// Three-stage Mitchell-approximation divider q ~ X/Y * 2^QF with valid/ready
// flow control and full throughput under backpressure.
module log_divider_pipe
   import log_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int YW = YW_DEF,
   parameter int FW = FW_DEF,
   parameter int QW = QW_DEF,
   parameter int QF = QF_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW/2-1:0] x_hi,
   input  logic [DW/2-1:0] x_lo,
   input  logic [YW-1:0]   y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [QW-1:0]   q,
   output logic            dz
);

   localparam int KXW = kw_f(DW);
   localparam int KYW = kw_f(YW);
   localparam int LW  = lw_f(DW, YW, FW);
   localparam int RW  = FW + 1 + QW;

   typedef struct packed {
      logic [KXW-1:0] kx;
      logic [FW-1:0]  fx;
      logic [KYW-1:0] ky;
      logic [FW-1:0]  fy;
      zflags_t        z;
   } s1_t;

   typedef struct packed {
      logic [LW-1:0] l;
      zflags_t       z;
   } s2_t;

   s1_t s1_d, s1_q;
   s2_t s2_d, s2_q;
   logic s1_valid_q, s2_valid_q, s3_valid_q;
   logic [QW-1:0] q_d, q_q;
   logic dz_d, dz_q;
   logic ready1, ready2, ready3;

   // A stage may load when it is empty or the stage after it can take its data.
   assign ready3   = ~s3_valid_q | out_ready;
   assign ready2   = ~s2_valid_q | ready3;
   assign ready1   = ~s1_valid_q | ready2;
   assign in_ready = ready1;

   lod_norm #(.W(DW), .FW(FW)) u_lod_x (
      .val_i  ({x_hi, x_lo}),
      .k_o    (s1_d.kx),
      .f_o    (s1_d.fx),
      .zero_o (s1_d.z.zx)
   );

   lod_norm #(.W(YW), .FW(FW)) u_lod_y (
      .val_i  (y),
      .k_o    (s1_d.ky),
      .f_o    (s1_d.fy),
      .zero_o (s1_d.z.zy)
   );

   always_comb begin
      s2_d.l = (LW'(s1_q.kx) << FW) - (LW'(s1_q.ky) << FW)
             + LW'(s1_q.fx) - LW'(s1_q.fy);
      s2_d.z = s1_q.z;
   end

   logic signed [LW-1:0] e_s, s_s, ns_s;
   logic [FW:0]          mant;
   logic [RW-1:0]        r;
   logic                 sat;

   always_comb begin
      e_s  = $signed(s2_q.l) >>> FW;
      s_s  = e_s + LW'(QF) - LW'(FW);
      ns_s = -s_s;
      mant = {1'b1, s2_q.l[FW-1:0]};
      r    = '0;
      if (!s_s[LW-1]) begin
         // Beyond QW the shifted mantissa cannot fit; force saturation.
         if (s_s > LW'(QW)) r = '1;
         else               r = RW'(mant) << s_s;
      end else if (ns_s <= LW'(FW)) begin
         r = RW'(mant) >> ns_s;
      end
      sat = |r[RW-1:QW];

      dz_d = 1'b0;
      q_d  = sat ? '1 : r[QW-1:0];
      if (s2_q.z.zy) begin
         dz_d = 1'b1;
         q_d  = '1;
      end else if (s2_q.z.zx) begin
         q_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         q_q        <= '0;
         dz_q       <= 1'b0;
      end else begin
         if (ready1) s1_valid_q <= in_valid;
         if (ready2) s2_valid_q <= s1_valid_q;
         if (ready3) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
               q_q  <= q_d;
               dz_q <= dz_d;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ready1 && in_valid)   s1_q <= s1_d;
      if (ready2 && s1_valid_q) s2_q <= s2_d;
   end

   assign out_valid = s3_valid_q;
   assign q         = q_q;
   assign dz        = dz_q;

endmodule
